frag_instr_decoder: RTL and testbench
=====================================

# frag_instr_decoder

Sequential, parametrised instruction decoder for the CGRA fetch path. It accepts 32-bit instruction words over a valid/ready handshake and absorbs T and I prefixes into the next D or W word. It tracks fragment start/end markers and an allocation count, and emits one fully merged decoded record per D/W word through a registered valid/ready output. Protocol violations are reported on a one-cycle error strobe.

## Interface
- `NALLOC_W`, 7: width of the fragment allocation count, taken from `instr[NALLOC_W-1:0]`; legal range 1..24.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1, `in_ready` out 1, `in_instr` in 32: instruction word handshake.
- `out_valid` out 1, `out_ready` in 1: decoded record handshake.
- `out_op` out 3: opcode.
- `out_funct` out 4: function code.
- `out_immab` out 1: immediate select.
- `out_imm` out 32: merged immediate.
- `out_offset` out 10: W-word offset.
- `out_ta1..out_ta4` out 6 each, `out_tt1..out_tt4` out 2 each: target addresses and types.
- `out_has_t` out 1, `out_has_i` out 1: the record consumed a T or I prefix.
- `err_valid` out 1, `err_code` out 3: error strobe and code.
- `frag_active` out 1: a fragment is currently open.
- `frag_remaining` out NALLOC_W: D/W words left in the open fragment.

## Operation
- Opcode map, `instr[31:29]`:
  - 000/001: D word. funct=[28:25], immab=[24], immlo=[23:18], ta1=[5:0], tt1=[7:6], ta2=[13:8], tt2=[15:14].
  - 101: W word. funct, immab and immlo as for D; offset=[9:0].
  - 011: T prefix. ta3=[5:0], tt3=[7:6], ta4=[13:8], tt4=[15:14].
  - 100: I prefix. immhi=[25:0].
  - 110: fragment marker. endF=[28], nalloc=[NALLOC_W-1:0].
  - 010 and 111: illegal.
- Prefixes are held in pending registers and produce no output. The next D/W word consumes both pending registers and clears them.
- out_imm = {immhi, immlo} when an I prefix is pending; otherwise {26'b0, immlo}.
- Fields not supplied by the word or a prefix output 0: ta3/ta4/tt3/tt4 without a T prefix, offset for D words, ta1/ta2/tt1/tt2 for W words.
- Fragment FSM has two states, IDLE and ACTIVE; reset puts it in IDLE.
  - Start marker (endF=0): load frag_remaining=nalloc and go to ACTIVE. If already ACTIVE, also raise err 6 (nested).
  - End marker (endF=1) in ACTIVE: go to IDLE. Raise err 4 if frag_remaining≠0.
  - End marker in IDLE: err 3.
  - D/W in ACTIVE with frag_remaining>0: emit the record and decrement frag_remaining.
  - D/W in ACTIVE with frag_remaining=0: err 4; drop the word and clear pending prefixes.
  - D/W in IDLE: err 3; drop the word and clear pending prefixes.
- Error codes:
  - 1: duplicate prefix of the same kind. The newer prefix overwrites the older.
  - 2: a marker arrives while any prefix is pending. Pending prefixes are cleared, then the marker is processed.
  - 3: word outside a fragment.
  - 4: length mismatch or overrun.
  - 5: illegal opcode. The word is dropped; pending state is unchanged.
  - 6: nested start marker.
  - When err 2 coincides with a marker error, err 2 has priority and the marker error is suppressed.
- Prefixes are accepted in both IDLE and ACTIVE.

## Timing
- in_ready = !out_valid | out_ready. A word is accepted when in_valid & in_ready.
- Latency is one cycle: an accepted D/W word drives out_valid on the next edge.
- The output record holds stable while out_valid & !out_ready.
- Full throughput is one record per cycle when out_ready=1 continuously.
- err_valid is asserted for exactly the one cycle after the offending word is accepted. It never coincides with a record produced by the same word.
- Pending prefix, frag_remaining and FSM state update on the accepting edge.
- Reset values: out_valid=0, all out_* fields 0, err_valid=0, err_code=0, frag_active=0, frag_remaining=0, pending prefixes cleared.
- Asserting rst mid-stream discards any unaccepted output record and all pending state immediately.

## Configuration
- `FRAG_DEC_IMM_SEXT_EN` defined: when no I prefix is pending, out_imm sign-extends immlo[5] into bits 31:6. A merged I prefix is unaffected.
- Not defined: immediate zero-extended as above.

## Test plan
- Start marker nalloc=2, D word funct=3 immlo=5 ta1=9, D word -> two records out_imm=5, then frag_remaining=0. End marker -> IDLE with no error.
- In ACTIVE: T prefix ta3=7 tt4=2, I prefix immhi=1, W word offset=0x3FF immlo=0x3F -> single record: out_imm=0x7F, out_has_t=out_has_i=1, ta3=7, tt4=2, offset=0x3FF.
- Protocol errors, in order:
  - D word in IDLE -> err 3, no record.
  - Start marker nalloc=1, then 2 D words -> second gives err 4.
  - Two consecutive I prefixes -> err 1, and the second immhi is used.
  - Opcode 111 -> err 5.
- Backpressure: hold out_ready=0 for 5 cycles with a record pending -> in_ready=0 and the record holds stable. Release -> next word accepted the same cycle.
- With `FRAG_DEC_IMM_SEXT_EN`: D word immlo=0x20 without I prefix -> out_imm=0xFFFFFFE0. Without the macro -> 0x00000020.
- Assert rst while out_valid=1 and frag_remaining=3 -> all outputs 0 and frag_active=0 on the same cycle.

Source files
------------

// File: rtl/frag_instr_decoder.sv
// frag_instr_decoder: merges T/I prefixes into D/W words and tracks fragments.
// Optional macro FRAG_DEC_IMM_SEXT_EN sign-extends immlo when no I prefix merges.
module frag_instr_decoder #(
    parameter int NALLOC_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_op,
    output logic [3:0]          out_funct,
    output logic                out_immab,
    output logic [31:0]         out_imm,
    output logic [9:0]          out_offset,
    output logic [5:0]          out_ta1,
    output logic [5:0]          out_ta2,
    output logic [5:0]          out_ta3,
    output logic [5:0]          out_ta4,
    output logic [1:0]          out_tt1,
    output logic [1:0]          out_tt2,
    output logic [1:0]          out_tt3,
    output logic [1:0]          out_tt4,
    output logic                out_has_t,
    output logic                out_has_i,
    output logic                err_valid,
    output logic [2:0]          err_code,
    output logic                frag_active,
    output logic [NALLOC_W-1:0] frag_remaining
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [NALLOC_W-1:0] ONE = {{(NALLOC_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [NALLOC_W-1:0] r_remaining;
    logic                r_pend_t;
    logic                r_pend_i;
    logic [15:0]         r_tpre;
    logic [25:0]         r_immhi;
    logic                r_err_valid;
    logic [2:0]          r_err_code;

    logic                r_out_valid;
    logic [2:0]          r_op;
    logic [3:0]          r_funct;
    logic                r_immab;
    logic [31:0]         r_imm;
    logic [9:0]          r_offset;
    logic [15:0]         r_t12;
    logic [15:0]         r_t34;
    logic                r_has_t;
    logic                r_has_i;

    logic [2:0]          w_op;
    logic                w_accept;
    logic                w_is_d;
    logic                w_is_w;
    logic                w_is_dw;
    logic                w_end;
    logic                w_active;
    logic                w_can_emit;
    logic                w_emit;
    logic                w_err;
    logic [2:0]          w_err_code;
    logic [5:0]          w_immlo;
    logic [31:0]         w_imm_noi;
    logic [31:0]         w_imm;

    assign in_ready   = !r_out_valid | out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_op       = in_instr[31:29];
    assign w_is_d     = (w_op == 3'b000) | (w_op == 3'b001);
    assign w_is_w     = (w_op == 3'b101);
    assign w_is_dw    = w_is_d | w_is_w;
    assign w_end      = in_instr[28];
    assign w_active   = (r_state == S_ACTIVE);
    assign w_can_emit = w_active & (r_remaining != '0);
    assign w_emit     = w_accept & w_is_dw & w_can_emit;
    assign w_immlo    = in_instr[23:18];

`ifdef FRAG_DEC_IMM_SEXT_EN
    assign w_imm_noi = {{26{w_immlo[5]}}, w_immlo};
`else
    assign w_imm_noi = {26'b0, w_immlo};
`endif

    assign w_imm = r_pend_i ? {r_immhi, w_immlo} : w_imm_noi;

    // Classify the accepted word into at most one error code.
    always_comb begin
        w_err      = 1'b0;
        w_err_code = 3'd0;
        if (w_accept) begin
            case (w_op)
                3'b011: begin
                    w_err      = r_pend_t;
                    w_err_code = 3'd1;
                end
                3'b100: begin
                    w_err      = r_pend_i;
                    w_err_code = 3'd1;
                end
                3'b110: begin
                    w_err = 1'b1;
                    if (r_pend_t | r_pend_i)
                        w_err_code = 3'd2;
                    else if (!w_end && w_active)
                        w_err_code = 3'd6;
                    else if (w_end && w_active && r_remaining != '0)
                        w_err_code = 3'd4;
                    else if (w_end && !w_active)
                        w_err_code = 3'd3;
                    else
                        w_err = 1'b0;
                end
                3'b010, 3'b111: begin
                    w_err      = 1'b1;
                    w_err_code = 3'd5;
                end
                default: begin
                    if (!w_active) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd3;
                    end else if (r_remaining == '0) begin
                        w_err      = 1'b1;
                        w_err_code = 3'd4;
                    end
                end
            endcase
        end
    end

    // Fragment FSM, pending prefixes and error strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_pend_t    <= 1'b0;
            r_pend_i    <= 1'b0;
            r_tpre      <= '0;
            r_immhi     <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_err_valid <= w_err;
            if (w_err)
                r_err_code <= w_err_code;
            if (w_accept) begin
                case (w_op)
                    3'b011: begin
                        r_pend_t <= 1'b1;
                        r_tpre   <= in_instr[15:0];
                    end
                    3'b100: begin
                        r_pend_i <= 1'b1;
                        r_immhi  <= in_instr[25:0];
                    end
                    3'b110: begin
                        r_pend_t <= 1'b0;
                        r_pend_i <= 1'b0;
                        if (!w_end) begin
                            r_state     <= S_ACTIVE;
                            r_remaining <= in_instr[NALLOC_W-1:0];
                        end else if (w_active) begin
                            r_state     <= S_IDLE;
                            r_remaining <= '0;
                        end
                    end
                    3'b010, 3'b111: begin
                    end
                    default: begin
                        r_pend_t <= 1'b0;
                        r_pend_i <= 1'b0;
                        if (w_can_emit)
                            r_remaining <= r_remaining - ONE;
                    end
                endcase
            end
        end
    end

    // Output record register with valid/ready hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_funct     <= '0;
            r_immab     <= 1'b0;
            r_imm       <= '0;
            r_offset    <= '0;
            r_t12       <= '0;
            r_t34       <= '0;
            r_has_t     <= 1'b0;
            r_has_i     <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_op        <= w_op;
            r_funct     <= in_instr[28:25];
            r_immab     <= in_instr[24];
            r_imm       <= w_imm;
            r_offset    <= w_is_w ? in_instr[9:0] : 10'd0;
            r_t12       <= w_is_d ? in_instr[15:0] : 16'd0;
            r_t34       <= r_pend_t ? r_tpre : 16'd0;
            r_has_t     <= r_pend_t;
            r_has_i     <= r_pend_i;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_op         = r_op;
    assign out_funct      = r_funct;
    assign out_immab      = r_immab;
    assign out_imm        = r_imm;
    assign out_offset     = r_offset;
    assign out_ta1        = r_t12[5:0];
    assign out_tt1        = r_t12[7:6];
    assign out_ta2        = r_t12[13:8];
    assign out_tt2        = r_t12[15:14];
    assign out_ta3        = r_t34[5:0];
    assign out_tt3        = r_t34[7:6];
    assign out_ta4        = r_t34[13:8];
    assign out_tt4        = r_t34[15:14];
    assign out_has_t      = r_has_t;
    assign out_has_i      = r_has_i;
    assign err_valid      = r_err_valid;
    assign err_code       = r_err_code;
    assign frag_active    = (r_state == S_ACTIVE);
    assign frag_remaining = r_remaining;

endmodule

// File: tb/tb_frag_instr_decoder.sv
// tb_frag_instr_decoder: directed vectors for frag_instr_decoder.
// Expected values are hand-computed from the instruction encodings.
module tb_frag_instr_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_op;
    logic [3:0]  out_funct;
    logic        out_immab;
    logic [31:0] out_imm;
    logic [9:0]  out_offset;
    logic [5:0]  out_ta1, out_ta2, out_ta3, out_ta4;
    logic [1:0]  out_tt1, out_tt2, out_tt3, out_tt4;
    logic        out_has_t, out_has_i;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        frag_active;
    logic [6:0]  frag_remaining;

    int errors = 0;
    int checks = 0;

    frag_instr_decoder #(.NALLOC_W(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct(out_funct), .out_immab(out_immab),
        .out_imm(out_imm), .out_offset(out_offset),
        .out_ta1(out_ta1), .out_ta2(out_ta2),
        .out_ta3(out_ta3), .out_ta4(out_ta4),
        .out_tt1(out_tt1), .out_tt2(out_tt2),
        .out_tt3(out_tt3), .out_tt4(out_tt4),
        .out_has_t(out_has_t), .out_has_i(out_has_i),
        .err_valid(err_valid), .err_code(err_code),
        .frag_active(frag_active), .frag_remaining(frag_remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word for one edge; outputs are sampled 1ns after it.
    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 32'd0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_active", frag_active, 0);
        chk("rst_remaining", frag_remaining, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // start nalloc=2, two D words, end marker
        send(32'hC000_0002);
        chk("s1_active", frag_active, 1);
        chk("s1_rem", frag_remaining, 2);
        chk("s1_err", err_valid, 0);
        send(32'h0614_0009);
        chk("d1_valid", out_valid, 1);
        chk("d1_op", out_op, 0);
        chk("d1_funct", out_funct, 3);
        chk("d1_imm", out_imm, 5);
        chk("d1_ta1", out_ta1, 9);
        chk("d1_ta3", out_ta3, 0);
        chk("d1_has_t", out_has_t, 0);
        chk("d1_rem", frag_remaining, 1);
        chk("d1_err", err_valid, 0);
        send(32'h0614_0009);
        chk("d2_valid", out_valid, 1);
        chk("d2_imm", out_imm, 5);
        chk("d2_rem", frag_remaining, 0);
        send(32'hD000_0000);
        chk("e1_valid", out_valid, 0);
        chk("e1_active", frag_active, 0);
        chk("e1_err", err_valid, 0);

        // T + I + W merge
        send(32'hC000_0003);
        send(32'h6000_8007);
        chk("t_no_out", out_valid, 0);
        chk("t_err", err_valid, 0);
        send(32'h8000_0001);
        chk("i_no_out", out_valid, 0);
        send(32'hA0FC_03FF);
        chk("w_valid", out_valid, 1);
        chk("w_op", out_op, 5);
        chk("w_imm", out_imm, 32'h7F);
        chk("w_has_t", out_has_t, 1);
        chk("w_has_i", out_has_i, 1);
        chk("w_ta3", out_ta3, 7);
        chk("w_tt4", out_tt4, 2);
        chk("w_offset", out_offset, 10'h3FF);
        chk("w_ta1", out_ta1, 0);
        chk("w_rem", frag_remaining, 2);
        send(32'h0004_0000);
        chk("dp_has_t", out_has_t, 0);
        chk("dp_has_i", out_has_i, 0);
        chk("dp_imm", out_imm, 1);
        send(32'hD000_0000);
        chk("e2_err", err_valid, 1);
        chk("e2_code", err_code, 4);
        chk("e2_active", frag_active, 0);

        // D word in IDLE
        send(32'h0614_0009);
        chk("idle_err", err_valid, 1);
        chk("idle_code", err_code, 3);
        chk("idle_no_out", out_valid, 0);

        // overrun with nalloc=1
        send(32'hC000_0001);
        chk("s3_err_drop", err_valid, 0);
        send(32'h0614_0009);
        chk("o1_valid", out_valid, 1);
        chk("o1_rem", frag_remaining, 0);
        send(32'h0614_0009);
        chk("o2_err", err_valid, 1);
        chk("o2_code", err_code, 4);
        chk("o2_no_out", out_valid, 0);
        send(32'hD000_0000);
        chk("e3_err", err_valid, 0);

        // duplicate I prefix
        send(32'hC000_0002);
        send(32'h8000_0002);
        send(32'h8000_0003);
        chk("dup_err", err_valid, 1);
        chk("dup_code", err_code, 1);
        send(32'h0004_0000);
        chk("dup_imm", out_imm, 32'hC1);
        chk("dup_has_i", out_has_i, 1);
        chk("dup_next_err", err_valid, 0);

        // illegal opcode
        send(32'hE000_0000);
        chk("ill_err", err_valid, 1);
        chk("ill_code", err_code, 5);
        chk("ill_rem", frag_remaining, 1);

        // marker with prefix pending: err 2 beats nested err 6
        send(32'h6000_0000);
        send(32'hC000_0002);
        chk("mp_err", err_valid, 1);
        chk("mp_code", err_code, 2);
        chk("mp_rem", frag_remaining, 2);

        // backpressure
        out_ready = 1'b0;
        send(32'h0AA8_D100);
        chk("bp_valid", out_valid, 1);
        chk("bp_has_t", out_has_t, 0);
        chk("bp_rem", frag_remaining, 1);
        in_valid = 1'b1;
        in_instr = 32'h0004_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_funct", out_funct, 5);
            chk("bp_hold_imm", out_imm, 32'h2A);
            chk("bp_hold_ta2", out_ta2, 6'h11);
            chk("bp_hold_tt2", out_tt2, 3);
            chk("bp_hold_rem", frag_remaining, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_acc_valid", out_valid, 1);
        chk("bp_acc_imm", out_imm, 1);
        chk("bp_acc_funct", out_funct, 0);
        chk("bp_acc_rem", frag_remaining, 0);

        // immediate extension, then reset mid-stream
        send(32'hD000_0000);
        send(32'hC000_0004);
        send(32'h0080_0000);
`ifdef FRAG_DEC_IMM_SEXT_EN
        chk("sext_imm", out_imm, 32'hFFFF_FFE0);
`else
        chk("zext_imm", out_imm, 32'h0000_0020);
`endif
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_rem", frag_remaining, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_active", frag_active, 0);
        chk("mrst_rem", frag_remaining, 0);
        chk("mrst_imm", out_imm, 0);
        chk("mrst_funct", out_funct, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h0004_0000);
        chk("post_rst_err", err_valid, 1);
        chk("post_rst_code", err_code, 3);
        chk("post_rst_out", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
